// File: rtl/muldiv_unit_if.sv
// Bus between the controller and the multiply/divide unit.
//   start/flush/funct/a/b : issue side, driven by the controller (master)
//   busy/done/divz/illegal: status back to the controller
//   hi/lo/result          : HI/LO registers and the mfhi/mflo read port
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             divz;
  logic             illegal;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] result;

  modport master (
    output start, flush, funct, a, b,
    input  busy, done, divz, illegal, hi, lo, result
  );

  modport slave (
    input  start, flush, funct, a, b,
    output busy, done, divz, illegal, hi, lo, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers (MIPS mult/multu/div/divu,
// mfhi/mthi/mflo/mtlo). One operand bit is processed per cycle: shift-add multiply
// or restoring divide on magnitudes, followed by a single sign-fix cycle.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - muldiv_unit_if slave: start/flush/funct/a/b in;
//              busy/done/divz/illegal/hi/lo/result out
module muldiv_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          ENABLE_DIV = 1'b1
) (
  input logic          clk,
  input logic          reset_n,
  muldiv_unit_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMthi  = 6'b010001;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMtlo  = 6'b010011;
  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // acc: product high half / partial remainder (holds dividend a on divide-by-zero)
  // quo: multiplier shifting out / dividend shifting out, quotient shifting in
  // opd: multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             divz_q, divz_d;
  logic             illegal_q, illegal_d;

  // Operand magnitudes; funct[0]=0 selects the signed forms.
  logic             op_signed;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_signed = ~bus.funct[0];
  assign a_mag     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Multiply step: conditionally add multiplicand, shift {acc,quo} right by one.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q} + ({1'b0, opd_q} & {(WIDTH + 1){quo_q[0]}});

  // Restoring divide step. The shifted remainder is below 2*divisor, so once it is
  // known to be >= divisor the difference fits in WIDTH bits.
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;
  assign rem_sh  = {acc_q, quo_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, opd_q};
  assign rem_sub = rem_sh[WIDTH-1:0] - opd_q;

  logic [2*WIDTH-1:0] prod, prod_fix;
  assign prod     = {acc_q, quo_q};
  assign prod_fix = neg_res_q ? -prod : prod;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    opd_d     = opd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    illegal_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A flushed issue slot never starts anything.
        if (bus.start && !bus.flush) begin
          case (bus.funct)
            FnMthi: hi_d = bus.a;
            FnMtlo: lo_d = bus.a;
            FnMfhi, FnMflo: ;
            FnMult, FnMultu: begin
              acc_d     = '0;
              quo_d     = b_mag;
              opd_d     = a_mag;
              is_div_d  = 1'b0;
              neg_res_d = op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              neg_rem_d = 1'b0;
              divz_d    = 1'b0;
              cnt_d     = '0;
              state_d   = StCalc;
            end
            FnDiv, FnDivu: begin
              if (!ENABLE_DIV) begin
                illegal_d = 1'b1;
              end else if (bus.b == '0) begin
                acc_d    = bus.a;
                is_div_d = 1'b1;
                divz_d   = 1'b1;
                state_d  = StFix;
              end else begin
                acc_d     = '0;
                quo_d     = a_mag;
                opd_d     = b_mag;
                is_div_d  = 1'b1;
                neg_res_d = op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_rem_d = op_signed & bus.a[WIDTH-1];
                divz_d    = 1'b0;
                cnt_d     = '0;
                state_d   = StCalc;
              end
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end

      StCalc: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          if (is_div_q) begin
            acc_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], rem_ge};
          end else begin
            acc_d = mul_sum[WIDTH:1];
            quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
          end
          if (cnt_q == CntLast) begin
            state_d = StFix;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StFix: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          if (divz_q) begin
            hi_d = acc_q;
            lo_d = '1;
          end else if (is_div_q) begin
            hi_d = neg_rem_q ? -acc_q : acc_q;
            lo_d = neg_res_q ? -quo_q : quo_q;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          state_d = StDone;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      opd_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      opd_q     <= opd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.busy    = (state_q == StCalc) || (state_q == StFix);
  assign bus.done    = (state_q == StDone);
  assign bus.divz    = (state_q == StDone) && divz_q;
  assign bus.illegal = illegal_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.result  = (bus.funct == FnMfhi) ? hi_q :
                       (bus.funct == FnMflo) ? lo_q : '0;

endmodule
